// File: rtl/bp_cce_msg_mode_arb.sv
// ---------------------------------------------------------------------------
// bp_cce_msg_mode_arb
//
// Routes the CCE message channels (LCE request/response/command and memory
// command/response) between num_engines_p message engines. The engine that
// owns the channels is selected by mode_i (engine index == mode encoding).
// A mode change is drained: the owning engine stops receiving new LCE work
// and stops issuing memory commands, keeps receiving memory responses and
// keeps sending LCE commands until it has no memory commands in flight and
// no LCE command pending. Only then does ownership move, through a one-cycle
// gap in which nothing is routed.
//
// Ports
//   clk_i, reset_n_i              clock, asynchronous active-low reset
//   mode_i                        requested owning engine
//   lce_req_*, lce_resp_*,        inbound channels from the CCE queues
//   mem_resp_*                    (payload, valid in; yumi out)
//   lce_cmd_*, mem_cmd_*          outbound channels to the CCE queues
//                                 (payload, valid out; ready in)
//   eng_*                         packed per-engine copies of each channel,
//                                 opposite direction (engine i at slice i)
//   active_o                      engine currently owning the channels
//   switching_o                   a mode change is in progress
//   outstanding_o                 memory commands in flight for active_o
//
// Optional build macro
//   BP_CCE_MODE_ARB_STATS_EN      adds switch_count_o (ownership handovers,
//                                 wrapping) and drain_cycles_o (cycles spent
//                                 draining, saturating). Absent by default.
//
// mode_i must always carry a value below num_engines_p.
// ---------------------------------------------------------------------------
module bp_cce_msg_mode_arb #(
    parameter int num_engines_p     = 2,
    parameter int lce_req_width_p   = 128,
    parameter int lce_resp_width_p  = 128,
    parameter int lce_cmd_width_p   = 128,
    parameter int mem_msg_width_p   = 128,
    parameter int max_outstanding_p = 4,
    parameter logic [num_engines_p-1:0] resp_en_mask_p = 2'b01,
    localparam int mode_width_lp = (num_engines_p > 1) ? $clog2(num_engines_p) : 1,
    localparam int cnt_width_lp  = $clog2(max_outstanding_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [mode_width_lp-1:0]               mode_i,

    input  logic [lce_req_width_p-1:0]             lce_req_i,
    input  logic                                   lce_req_v_i,
    output logic                                   lce_req_yumi_o,
    input  logic [lce_resp_width_p-1:0]            lce_resp_i,
    input  logic                                   lce_resp_v_i,
    output logic                                   lce_resp_yumi_o,
    input  logic [mem_msg_width_p-1:0]             mem_resp_i,
    input  logic                                   mem_resp_v_i,
    output logic                                   mem_resp_yumi_o,
    output logic [lce_cmd_width_p-1:0]             lce_cmd_o,
    output logic                                   lce_cmd_v_o,
    input  logic                                   lce_cmd_ready_i,
    output logic [mem_msg_width_p-1:0]             mem_cmd_o,
    output logic                                   mem_cmd_v_o,
    input  logic                                   mem_cmd_ready_i,

    output logic [num_engines_p*lce_req_width_p-1:0]  eng_lce_req_o,
    output logic [num_engines_p-1:0]               eng_lce_req_v_o,
    input  logic [num_engines_p-1:0]               eng_lce_req_yumi_i,
    output logic [num_engines_p*lce_resp_width_p-1:0] eng_lce_resp_o,
    output logic [num_engines_p-1:0]               eng_lce_resp_v_o,
    input  logic [num_engines_p-1:0]               eng_lce_resp_yumi_i,
    output logic [num_engines_p*mem_msg_width_p-1:0]  eng_mem_resp_o,
    output logic [num_engines_p-1:0]               eng_mem_resp_v_o,
    input  logic [num_engines_p-1:0]               eng_mem_resp_yumi_i,
    input  logic [num_engines_p*lce_cmd_width_p-1:0]  eng_lce_cmd_i,
    input  logic [num_engines_p-1:0]               eng_lce_cmd_v_i,
    output logic [num_engines_p-1:0]               eng_lce_cmd_ready_o,
    input  logic [num_engines_p*mem_msg_width_p-1:0]  eng_mem_cmd_i,
    input  logic [num_engines_p-1:0]               eng_mem_cmd_v_i,
    output logic [num_engines_p-1:0]               eng_mem_cmd_ready_o,

`ifdef BP_CCE_MODE_ARB_STATS_EN
    output logic [31:0]                            switch_count_o,
    output logic [31:0]                            drain_cycles_o,
`endif
    output logic [mode_width_lp-1:0]               active_o,
    output logic                                   switching_o,
    output logic [cnt_width_lp-1:0]                outstanding_o
);

    // state        | meaning
    // state_run    | active engine owns every channel
    // state_drain  | no new LCE work / mem cmds; waiting for in-flight traffic to resolve
    // state_switch | one idle cycle, ownership moves to target_r
    localparam logic [1:0] state_run    = 2'd0;
    localparam logic [1:0] state_drain  = 2'd1;
    localparam logic [1:0] state_switch = 2'd2;

    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(max_outstanding_p);

    logic [1:0]               state_r;
    logic [mode_width_lp-1:0] active_r;
    logic [mode_width_lp-1:0] target_r;
    logic [cnt_width_lp-1:0]  cnt_r;

    // Routing enables also depend on reset_n_i so that nothing is handed
    // across while reset is held, not only after the next clock.
    logic route_any;
    logic route_new;
    logic mem_cmd_ok;
    logic resp_ok;
    logic mem_cmd_fire;
    logic mem_resp_fire;

    assign route_any  = reset_n_i & (state_r != state_switch);
    assign route_new  = reset_n_i & (state_r == state_run);
    assign mem_cmd_ok = route_new & (cnt_r != cnt_max_lp);
    assign resp_ok    = route_new & resp_en_mask_p[active_r];

    always_comb begin
        eng_lce_req_o  = {num_engines_p{lce_req_i}};
        eng_lce_resp_o = {num_engines_p{lce_resp_i}};
        eng_mem_resp_o = {num_engines_p{mem_resp_i}};

        eng_lce_req_v_o     = '0;
        eng_lce_resp_v_o    = '0;
        eng_mem_resp_v_o    = '0;
        eng_lce_cmd_ready_o = '0;
        eng_mem_cmd_ready_o = '0;

        eng_lce_req_v_o[active_r]     = route_new & lce_req_v_i;
        eng_lce_resp_v_o[active_r]    = resp_ok & lce_resp_v_i;
        eng_mem_resp_v_o[active_r]    = route_any & mem_resp_v_i;
        eng_lce_cmd_ready_o[active_r] = route_any & lce_cmd_ready_i;
        eng_mem_cmd_ready_o[active_r] = mem_cmd_ok & mem_cmd_ready_i;

        lce_req_yumi_o  = route_new & lce_req_v_i & eng_lce_req_yumi_i[active_r];
        lce_resp_yumi_o = resp_ok & lce_resp_v_i & eng_lce_resp_yumi_i[active_r];
        mem_resp_yumi_o = route_any & mem_resp_v_i & eng_mem_resp_yumi_i[active_r];

        lce_cmd_o   = eng_lce_cmd_i[active_r * lce_cmd_width_p +: lce_cmd_width_p];
        lce_cmd_v_o = route_any & eng_lce_cmd_v_i[active_r];
        mem_cmd_o   = eng_mem_cmd_i[active_r * mem_msg_width_p +: mem_msg_width_p];
        // Valid is gated with the same enable as ready so the count only
        // moves on handshakes the engine itself sees.
        mem_cmd_v_o = mem_cmd_ok & eng_mem_cmd_v_i[active_r];
    end

    assign mem_cmd_fire  = mem_cmd_v_o & mem_cmd_ready_i;
    // A response with nothing outstanding is still delivered but not counted.
    assign mem_resp_fire = mem_resp_v_i & mem_resp_yumi_o & (cnt_r != '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else if (mem_cmd_fire && !mem_resp_fire) begin
            cnt_r <= cnt_r + 1'b1;
        end else if (mem_resp_fire && !mem_cmd_fire) begin
            cnt_r <= cnt_r - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= state_run;
            active_r <= '0;
            target_r <= '0;
        end else begin
            case (state_r)
                state_run: begin
                    if (mode_i != active_r) begin
                        state_r  <= state_drain;
                        target_r <= mode_i;
                    end
                end
                state_drain: begin
                    if (mode_i == active_r) begin
                        state_r <= state_run;
                    end else begin
                        target_r <= mode_i;
                        if ((cnt_r == '0) && !eng_lce_cmd_v_i[active_r]) begin
                            state_r <= state_switch;
                        end
                    end
                end
                state_switch: begin
                    active_r <= target_r;
                    state_r  <= state_run;
                end
                default: state_r <= state_run;
            endcase
        end
    end

    assign active_o      = active_r;
    assign switching_o   = (state_r != state_run);
    assign outstanding_o = cnt_r;

`ifdef BP_CCE_MODE_ARB_STATS_EN
    logic [31:0] switch_count_r;
    logic [31:0] drain_cycles_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            switch_count_r <= '0;
            drain_cycles_r <= '0;
        end else begin
            if (state_r == state_switch) begin
                switch_count_r <= switch_count_r + 32'd1;
            end
            if ((state_r == state_drain) && (drain_cycles_r != '1)) begin
                drain_cycles_r <= drain_cycles_r + 32'd1;
            end
        end
    end

    assign switch_count_o = switch_count_r;
    assign drain_cycles_o = drain_cycles_r;
`endif

endmodule

// File: tb/tb_bp_cce_msg_mode_arb.sv
module tb_bp_cce_msg_mode_arb;

    localparam int N   = 2;
    localparam int W   = 128;
    localparam int MAX = 4;
    localparam logic [N-1:0] RESP_MASK = 2'b01;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic           reset_n_i;
    logic [0:0]     mode_i;
    logic [W-1:0]   lce_req_i, lce_resp_i, mem_resp_i;
    logic           lce_req_v_i, lce_resp_v_i, mem_resp_v_i;
    logic           lce_req_yumi_o, lce_resp_yumi_o, mem_resp_yumi_o;
    logic [W-1:0]   lce_cmd_o, mem_cmd_o;
    logic           lce_cmd_v_o, mem_cmd_v_o, lce_cmd_ready_i, mem_cmd_ready_i;
    logic [N*W-1:0] eng_lce_req_o, eng_lce_resp_o, eng_mem_resp_o;
    logic [N-1:0]   eng_lce_req_v_o, eng_lce_resp_v_o, eng_mem_resp_v_o;
    logic [N-1:0]   eng_lce_req_yumi_i, eng_lce_resp_yumi_i, eng_mem_resp_yumi_i;
    logic [N*W-1:0] eng_lce_cmd_i, eng_mem_cmd_i;
    logic [N-1:0]   eng_lce_cmd_v_i, eng_mem_cmd_v_i;
    logic [N-1:0]   eng_lce_cmd_ready_o, eng_mem_cmd_ready_o;
    logic [0:0]     active_o;
    logic           switching_o;
    logic [2:0]     outstanding_o;

    bp_cce_msg_mode_arb dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .mode_i(mode_i),
        .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i), .lce_req_yumi_o(lce_req_yumi_o),
        .lce_resp_i(lce_resp_i), .lce_resp_v_i(lce_resp_v_i), .lce_resp_yumi_o(lce_resp_yumi_o),
        .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
        .lce_cmd_o(lce_cmd_o), .lce_cmd_v_o(lce_cmd_v_o), .lce_cmd_ready_i(lce_cmd_ready_i),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
        .eng_lce_req_o(eng_lce_req_o), .eng_lce_req_v_o(eng_lce_req_v_o),
        .eng_lce_req_yumi_i(eng_lce_req_yumi_i),
        .eng_lce_resp_o(eng_lce_resp_o), .eng_lce_resp_v_o(eng_lce_resp_v_o),
        .eng_lce_resp_yumi_i(eng_lce_resp_yumi_i),
        .eng_mem_resp_o(eng_mem_resp_o), .eng_mem_resp_v_o(eng_mem_resp_v_o),
        .eng_mem_resp_yumi_i(eng_mem_resp_yumi_i),
        .eng_lce_cmd_i(eng_lce_cmd_i), .eng_lce_cmd_v_i(eng_lce_cmd_v_i),
        .eng_lce_cmd_ready_o(eng_lce_cmd_ready_o),
        .eng_mem_cmd_i(eng_mem_cmd_i), .eng_mem_cmd_v_i(eng_mem_cmd_v_i),
        .eng_mem_cmd_ready_o(eng_mem_cmd_ready_o),
        .active_o(active_o), .switching_o(switching_o), .outstanding_o(outstanding_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: who owns the channels, whether a handover is pending,
    // and how many memory commands the owner has in flight.
    int owner, target, inflight;
    bit draining, handover;
    int handovers;

    function automatic void model_reset();
        owner = 0; target = 0; inflight = 0;
        draining = 0; handover = 0;
    endfunction

    function automatic logic [W-1:0] rnd_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_idle();
        lce_req_v_i = 0; lce_resp_v_i = 0; mem_resp_v_i = 0;
        lce_cmd_ready_i = 0; mem_cmd_ready_i = 0;
        eng_lce_req_yumi_i = '0; eng_lce_resp_yumi_i = '0; eng_mem_resp_yumi_i = '0;
        eng_lce_cmd_v_i = '0; eng_mem_cmd_v_i = '0;
        lce_req_i = rnd_w(); lce_resp_i = rnd_w(); mem_resp_i = rnd_w();
        eng_lce_cmd_i = {rnd_w(), rnd_w()}; eng_mem_cmd_i = {rnd_w(), rnd_w()};
    endtask

    task automatic set_random(input int resp_pct, input int mode_pct);
        set_idle();
        lce_req_v_i = 1'($urandom_range(0, 1));
        lce_resp_v_i = 1'($urandom_range(0, 1));
        mem_resp_v_i = ($urandom_range(0, 99) < resp_pct);
        lce_cmd_ready_i = 1'($urandom_range(0, 1));
        mem_cmd_ready_i = ($urandom_range(0, 99) < 70);
        eng_lce_req_yumi_i = 2'($urandom);
        eng_lce_resp_yumi_i = 2'($urandom);
        eng_mem_resp_yumi_i = 2'($urandom_range(1, 3));
        eng_lce_cmd_v_i = 2'($urandom);
        eng_mem_cmd_v_i = 2'($urandom);
        if ($urandom_range(0, 99) < mode_pct) mode_i = ~mode_i;
    endtask

    // Inputs are set just after a rising edge; outputs are compared mid-cycle,
    // then the model advances on the next rising edge.
    task automatic step();
        bit any, fresh, cmd_ok, rok;
        logic [N-1:0] e_req_v, e_resp_v, e_mresp_v, e_lrdy, e_mrdy;
        bit e_req_y, e_resp_y, e_mresp_y, e_lcmd_v, e_mcmd_v;
        int nxt;
        #2;
        if (!reset_n_i) model_reset();
        any    = reset_n_i && !handover;
        fresh  = any && !draining;
        cmd_ok = fresh && (inflight < MAX);
        rok    = fresh && RESP_MASK[owner];
        e_req_v   = (fresh && lce_req_v_i)     ? (N'(1) << owner) : '0;
        e_resp_v  = (rok && lce_resp_v_i)      ? (N'(1) << owner) : '0;
        e_mresp_v = (any && mem_resp_v_i)      ? (N'(1) << owner) : '0;
        e_lrdy    = (any && lce_cmd_ready_i)   ? (N'(1) << owner) : '0;
        e_mrdy    = (cmd_ok && mem_cmd_ready_i) ? (N'(1) << owner) : '0;
        e_req_y   = fresh && lce_req_v_i && eng_lce_req_yumi_i[owner];
        e_resp_y  = rok && lce_resp_v_i && eng_lce_resp_yumi_i[owner];
        e_mresp_y = any && mem_resp_v_i && eng_mem_resp_yumi_i[owner];
        e_lcmd_v  = any && eng_lce_cmd_v_i[owner];
        e_mcmd_v  = cmd_ok && eng_mem_cmd_v_i[owner];

        check("active", W'(active_o), W'(owner));
        check("switching", W'(switching_o), W'(draining || handover));
        check("outstanding", W'(outstanding_o), W'(inflight));
        check("eng_lce_req_v", W'(eng_lce_req_v_o), W'(e_req_v));
        check("lce_req_yumi", W'(lce_req_yumi_o), W'(e_req_y));
        check("eng_lce_resp_v", W'(eng_lce_resp_v_o), W'(e_resp_v));
        check("lce_resp_yumi", W'(lce_resp_yumi_o), W'(e_resp_y));
        check("eng_mem_resp_v", W'(eng_mem_resp_v_o), W'(e_mresp_v));
        check("mem_resp_yumi", W'(mem_resp_yumi_o), W'(e_mresp_y));
        check("lce_cmd_v", W'(lce_cmd_v_o), W'(e_lcmd_v));
        check("eng_lce_cmd_ready", W'(eng_lce_cmd_ready_o), W'(e_lrdy));
        check("mem_cmd_v", W'(mem_cmd_v_o), W'(e_mcmd_v));
        check("eng_mem_cmd_ready", W'(eng_mem_cmd_ready_o), W'(e_mrdy));
        if (e_req_v != 0) check("eng_lce_req_data", eng_lce_req_o[owner*W +: W], lce_req_i);
        if (e_mresp_v != 0) check("eng_mem_resp_data", eng_mem_resp_o[owner*W +: W], mem_resp_i);
        if (e_lcmd_v) check("lce_cmd_data", lce_cmd_o, eng_lce_cmd_i[owner*W +: W]);
        if (e_mcmd_v) check("mem_cmd_data", mem_cmd_o, eng_mem_cmd_i[owner*W +: W]);

        @(posedge clk_i);
        if (!reset_n_i) begin
            model_reset();
        end else begin
            nxt = inflight + int'(e_mcmd_v && mem_cmd_ready_i) - int'(e_mresp_y && inflight > 0);
            if (handover) begin
                owner = target; handover = 0; handovers++;
            end else if (draining) begin
                if (int'(mode_i) == owner) draining = 0;
                else begin
                    target = int'(mode_i);
                    if (inflight == 0 && !eng_lce_cmd_v_i[owner]) begin
                        draining = 0; handover = 1;
                    end
                end
            end else if (int'(mode_i) != owner) begin
                draining = 1; target = int'(mode_i);
            end
            inflight = nxt;
        end
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        mode_i = 0;
        reset_n_i = 0;
        step();
        reset_n_i = 1;
    endtask

    initial begin
        handovers = 0;
        model_reset();
        mode_i = 0;
        reset_n_i = 0;
        set_idle();
        @(posedge clk_i); #1;
        // reset state with traffic presented: nothing may pass
        set_random(50, 0);
        eng_mem_cmd_v_i = 2'b11; mem_cmd_ready_i = 1; lce_req_v_i = 1;
        step();
        reset_n_i = 1;

        // LCE requests to engine 0 only
        for (int i = 0; i < 3; i++) begin
            set_idle(); lce_req_v_i = 1; eng_lce_req_yumi_i = 2'b11;
            step();
        end

        // two mem_cmds, then switch to engine 1 once responses return
        for (int i = 0; i < 2; i++) begin
            set_idle(); eng_mem_cmd_v_i = 2'b01; mem_cmd_ready_i = 1;
            step();
        end
        mode_i = 1;
        for (int i = 0; i < 3; i++) begin
            set_idle(); lce_req_v_i = 1; eng_lce_req_yumi_i = 2'b11;
            step();
        end
        for (int i = 0; i < 4; i++) begin
            set_idle(); mem_resp_v_i = 1; eng_mem_resp_yumi_i = 2'b11;
            step();
        end
        check("switched_to_1", W'(active_o), W'(1));

        // abort: 1 -> 0 -> 1 while a command is outstanding
        set_idle(); eng_mem_cmd_v_i = 2'b10; mem_cmd_ready_i = 1;
        step();
        mode_i = 0; set_idle(); step();
        mode_i = 1; set_idle(); step();
        set_idle(); step();
        check("abort_keeps_owner", W'(active_o), W'(1));
        check("abort_outstanding", W'(outstanding_o), W'(1));

        // overflow guard: five commands with no responses
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_idle(); eng_mem_cmd_v_i = 2'b01; mem_cmd_ready_i = 1;
            step();
        end
        check("outstanding_at_max", W'(outstanding_o), W'(MAX));
        check("ready_blocked_at_max", W'(eng_mem_cmd_ready_o), W'(0));

        // simultaneous cmd and resp hold the count; resp at zero does not underflow
        for (int i = 0; i < 2; i++) begin
            set_idle(); mem_resp_v_i = 1; eng_mem_resp_yumi_i = 2'b01;
            step();
        end
        set_idle(); eng_mem_cmd_v_i = 2'b01; mem_cmd_ready_i = 1;
        mem_resp_v_i = 1; eng_mem_resp_yumi_i = 2'b01;
        step();
        check("hold_at_2", W'(outstanding_o), W'(2));
        for (int i = 0; i < 3; i++) begin
            set_idle(); mem_resp_v_i = 1; eng_mem_resp_yumi_i = 2'b01;
            step();
        end
        check("no_underflow", W'(outstanding_o), W'(0));

        // reset asserted mid-drain with three commands outstanding
        for (int i = 0; i < 3; i++) begin
            set_idle(); eng_mem_cmd_v_i = 2'b01; mem_cmd_ready_i = 1;
            step();
        end
        mode_i = 1; set_idle(); step();
        set_idle(); step();
        check("draining_before_reset", W'(switching_o), W'(1));
        set_random(50, 0);
        eng_mem_cmd_v_i = 2'b11; mem_cmd_ready_i = 1; mem_resp_v_i = 1; eng_lce_cmd_v_i = 2'b11;
        reset_n_i = 0;
        step();
        check("reset_outstanding", W'(outstanding_o), W'(0));
        reset_n_i = 1;
        mode_i = 0;

        // randomized traffic, slow mode changes
        for (int i = 0; i < 3000; i++) begin
            set_random((i < 1000) ? 20 : 50, 4);
            step();
        end
        // mode toggling every cycle
        for (int i = 0; i < 300; i++) begin
            set_random(40, 100);
            step();
        end
        // settle on one mode, let everything drain
        for (int i = 0; i < 200; i++) begin
            set_random(80, 0);
            step();
        end
        if (handovers == 0) check("handover_seen", W'(0), W'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
